// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered sync, DE and
// line/frame strobes, all decoded from the next-state position so they never skew.
module vga_timing_gen #(
  parameter int HSIZE = 640,
  parameter int HFP   = 16,
  parameter int HSW   = 96,
  parameter int HBP   = 48,
  parameter int VSIZE = 480,
  parameter int VFP   = 10,
  parameter int VSW   = 2,
  parameter int VBP   = 33,
  parameter int HPOL  = 0,
  parameter int VPOL  = 0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIX_EN,
  input  logic        RESTART,
  output logic        Hsync,
  output logic        Vsync,
  output logic        DE,
  output logic [10:0] hpos,
  output logic [9:0]  vpos,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);
  localparam int HTOTAL = HSIZE + HFP + HSW + HBP;
  localparam int VTOTAL = VSIZE + VFP + VSW + VBP;

  // One extra bit so bounds equal to HTOTAL/VTOTAL at the maximum still fit.
  localparam logic [11:0] H_ACT  = 12'(HSIZE);
  localparam logic [11:0] H_SS   = 12'(HSIZE + HFP);
  localparam logic [11:0] H_SE   = 12'(HSIZE + HFP + HSW);
  localparam logic [10:0] H_LAST = 11'(HTOTAL - 1);
  localparam logic [10:0] V_ACT  = 11'(VSIZE);
  localparam logic [10:0] V_SS   = 11'(VSIZE + VFP);
  localparam logic [10:0] V_SE   = 11'(VSIZE + VFP + VSW);
  localparam logic [9:0]  V_LAST = 10'(VTOTAL - 1);
  localparam logic        HS_ACT = 1'(HPOL);
  localparam logic        VS_ACT = 1'(VPOL);

  logic [10:0] h_adv, h_nxt;
  logic [9:0]  v_adv, v_nxt;
  logic        ls_nxt, fs_nxt;
  logic        de_nxt, hs_nxt, vs_nxt;

  always_comb begin
    h_adv = (hpos == H_LAST) ? 11'd0 : hpos + 11'd1;
    v_adv = vpos;
    if (hpos == H_LAST)
      v_adv = (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
  end

  always_comb begin
    h_nxt  = hpos;
    v_nxt  = vpos;
    ls_nxt = 1'b0;
    fs_nxt = 1'b0;
    if (RESTART) begin
      h_nxt = H_LAST;
      v_nxt = V_LAST;
    end else if (PIX_EN) begin
      h_nxt  = h_adv;
      v_nxt  = v_adv;
      ls_nxt = (h_adv == 11'd0);
      fs_nxt = (h_adv == 11'd0) && (v_adv == 10'd0);
    end
  end

  // Decode the position about to be registered, so syncs and DE land with it.
  always_comb begin
    de_nxt = ({1'b0, h_nxt} < H_ACT) && ({1'b0, v_nxt} < V_ACT);
    hs_nxt = ({1'b0, h_nxt} >= H_SS && {1'b0, h_nxt} < H_SE) ? HS_ACT : ~HS_ACT;
    vs_nxt = ({1'b0, v_nxt} >= V_SS && {1'b0, v_nxt} < V_SE) ? VS_ACT : ~VS_ACT;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hpos        <= H_LAST;
      vpos        <= V_LAST;
      DE          <= 1'b0;
      Hsync       <= ~HS_ACT;
      Vsync       <= ~VS_ACT;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 16'd0;
    end else begin
      hpos        <= h_nxt;
      vpos        <= v_nxt;
      DE          <= de_nxt;
      Hsync       <= hs_nxt;
      Vsync       <= vs_nxt;
      line_start  <= ls_nxt;
      frame_start <= fs_nxt;
      if (fs_nxt) frame_cnt <= frame_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 timing, a tiny inverted-polarity raster with a
// 1-in-4 pixel strobe, and a 1x1 raster used to wrap the frame counter quickly.
module tb_vga_timing_gen;
  logic CLK = 1'b0;
  logic RESET, PIX_EN, RESTART;
  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // d0: default timing
  logic d0_hs, d0_vs, d0_de, d0_ls, d0_fs;
  logic [10:0] d0_h;
  logic [9:0]  d0_v;
  logic [15:0] d0_fc;
  vga_timing_gen d0 (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .RESTART(RESTART),
    .Hsync(d0_hs), .Vsync(d0_vs), .DE(d0_de), .hpos(d0_h), .vpos(d0_v),
    .line_start(d0_ls), .frame_start(d0_fs), .frame_cnt(d0_fc));

  // d1: 16x8 total, active 8x4, hsync 10..12, vsync 5..6, active-high syncs
  logic d1_hs, d1_vs, d1_de, d1_ls, d1_fs;
  logic [10:0] d1_h;
  logic [9:0]  d1_v;
  logic [15:0] d1_fc;
  vga_timing_gen #(.HSIZE(8), .HFP(2), .HSW(3), .HBP(3),
                   .VSIZE(4), .VFP(1), .VSW(2), .VBP(1),
                   .HPOL(1), .VPOL(1)) d1 (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .RESTART(RESTART),
    .Hsync(d1_hs), .Vsync(d1_vs), .DE(d1_de), .hpos(d1_h), .vpos(d1_v),
    .line_start(d1_ls), .frame_start(d1_fs), .frame_cnt(d1_fc));

  // d2: 1x1 raster, one frame per advance
  logic d2_hs, d2_vs, d2_de, d2_ls, d2_fs;
  logic [10:0] d2_h;
  logic [9:0]  d2_v;
  logic [15:0] d2_fc;
  vga_timing_gen #(.HSIZE(1), .HFP(0), .HSW(0), .HBP(0),
                   .VSIZE(1), .VFP(0), .VSW(0), .VBP(0)) d2 (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .RESTART(RESTART),
    .Hsync(d2_hs), .Vsync(d2_vs), .DE(d2_de), .hpos(d2_h), .vpos(d2_v),
    .line_start(d2_ls), .frame_start(d2_fs), .frame_cnt(d2_fc));

  initial begin
    int de_cnt, de_last, hs_first, hs_last, hs_cnt, ls_cnt;
    logic de_at_640;
    int hc, vc, fs_seen, fs_cyc0, fs_cyc1, ls_frame;
    logic [63:0] exp;

    RESET = 1'b1; PIX_EN = 1'b0; RESTART = 1'b0;
    step(); step();
    chk("rst_pos",  {d0_h, d0_v}, {11'd799, 10'd524});
    chk("rst_de",   d0_de, 1'b0);
    chk("rst_sync", {d0_hs, d0_vs}, 2'b11);
    chk("rst_puls", {d0_ls, d0_fs}, 2'b00);
    chk("rst_fc",   d0_fc, 16'd0);

    RESET = 1'b0; PIX_EN = 1'b1;
    step();
    chk("first_pos",  {d0_h, d0_v}, {11'd0, 10'd0});
    chk("first_de",   d0_de, 1'b1);
    chk("first_puls", {d0_ls, d0_fs}, 2'b11);
    chk("first_fc",   d0_fc, 16'd1);

    de_cnt = 1; de_last = 0; hs_first = -1; hs_last = -1; hs_cnt = 0; ls_cnt = 0;
    de_at_640 = 1'b1;
    for (int i = 1; i < 800; i++) begin
      step();
      if (d0_de) begin de_cnt++; de_last = int'(d0_h); end
      if (d0_h == 11'd640) de_at_640 = d0_de;
      if (!d0_hs) begin
        if (hs_first < 0) hs_first = int'(d0_h);
        hs_last = int'(d0_h);
        hs_cnt++;
      end
      if (d0_ls || d0_fs) ls_cnt++;
    end
    chk("line_end_h", d0_h, 11'd799);
    chk("de_cnt",     de_cnt, 640);
    chk("de_last",    de_last, 639);
    chk("de_640",     de_at_640, 1'b0);
    chk("hs_first",   hs_first, 656);
    chk("hs_last",    hs_last, 751);
    chk("hs_cnt",     hs_cnt, 96);
    chk("no_midline_puls", ls_cnt, 0);
    chk("vs_line0",   d0_vs, 1'b1);

    step();
    chk("line1_pos",  {d0_h, d0_v}, {11'd0, 10'd1});
    chk("line1_puls", {d0_ls, d0_fs}, 2'b10);
    chk("line1_fc",   d0_fc, 16'd1);

    PIX_EN = 1'b0;
    step();
    chk("hold_pos",  {d0_h, d0_v}, {11'd0, 10'd1});
    chk("hold_puls", {d0_ls, d0_fs}, 2'b00);
    step(); step();
    chk("hold_out", {d0_de, d0_hs, d0_vs, d0_fc}, {3'b111, 16'd1});

    PIX_EN = 1'b1;
    repeat (300) step();
    chk("pre_rst_pos", {d0_h, d0_v}, {11'd300, 10'd1});
    RESTART = 1'b1;
    step();
    chk("restart_pos",  {d0_h, d0_v}, {11'd799, 10'd524});
    chk("restart_out",  {d0_de, d0_hs, d0_vs, d0_ls, d0_fs}, 5'b01100);
    chk("restart_fc",   d0_fc, 16'd1);
    RESTART = 1'b0;
    step();
    chk("post_restart_pos",  {d0_h, d0_v}, {11'd0, 10'd0});
    chk("post_restart_puls", {d0_ls, d0_fs}, 2'b11);
    chk("post_restart_fc",   d0_fc, 16'd2);

    repeat (10) step();
    #2 RESET = 1'b1;
    #1;
    chk("async_pos", {d0_h, d0_v}, {11'd799, 10'd524});
    chk("async_out", {d0_de, d0_hs, d0_vs, d0_ls, d0_fs, d0_fc}, {5'b01100, 16'd0});
    step();
    chk("in_rst_puls", {d0_ls, d0_fs, d0_h}, {2'b00, 11'd799});
    RESET = 1'b0;
    step();
    chk("rerelease", {d0_h, d0_v, d0_fs, d0_fc}, {11'd0, 10'd0, 1'b1, 16'd1});

    // Small raster with sparse strobe: compare every cycle against a counter model.
    RESET = 1'b1; PIX_EN = 1'b0;
    step();
    chk("d1_rst", {d1_h, d1_v, d1_hs, d1_vs, d1_de}, {11'd15, 10'd7, 3'b000});
    RESET = 1'b0;
    hc = 15; vc = 7; fs_seen = 0; fs_cyc0 = 0; fs_cyc1 = 0; ls_frame = 0;
    for (int cyc = 0; cyc < 257 * 4; cyc++) begin
      logic ls_e, fs_e;
      PIX_EN = (cyc % 4 == 0);
      ls_e = 1'b0; fs_e = 1'b0;
      if (PIX_EN) begin
        hc = (hc + 1) % 16;
        if (hc == 0) vc = (vc + 1) % 8;
        ls_e = (hc == 0);
        fs_e = ls_e && (vc == 0);
      end
      step();
      exp = {39'd0, 11'(hc), 10'(vc),
             1'(hc >= 10 && hc < 13), 1'(vc >= 5 && vc < 7),
             1'(hc < 8 && vc < 4), ls_e, fs_e};
      chk("d1_cycle", {39'd0, d1_h, d1_v, d1_hs, d1_vs, d1_de, d1_ls, d1_fs}, exp);
      if (fs_seen == 1 && d1_ls) ls_frame++;
      if (d1_fs) begin
        if (fs_seen == 0) fs_cyc0 = cyc;
        if (fs_seen == 1) fs_cyc1 = cyc;
        fs_seen++;
      end
    end
    chk("d1_fs_count",    fs_seen, 3);
    chk("d1_ls_perframe", ls_frame, 8);
    chk("d1_frame_period", fs_cyc1 - fs_cyc0, 512);
    chk("d1_fc",          d1_fc, 16'd3);

    // Frame counter wrap on the 1x1 raster.
    RESET = 1'b1; PIX_EN = 1'b0;
    step();
    chk("d2_rst_fc", d2_fc, 16'd0);
    RESET = 1'b0; PIX_EN = 1'b1;
    repeat (65535) step();
    chk("d2_fc_max", d2_fc, 16'hFFFF);
    step();
    chk("d2_fc_wrap", {d2_fs, d2_fc}, {1'b1, 16'h0000});

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- HSIZE, 640: active pixels per line.
- HFP, 16: horizontal front porch in pixels.
- HSW, 96: Hsync width in pixels.
- HBP, 48: horizontal back porch in pixels.
- VSIZE, 480: active lines per frame.
- VFP, 10: vertical front porch in lines.
- VSW, 2: Vsync width in lines.
- VBP, 33: vertical back porch in lines.
- HPOL, 0: Hsync active level.
- VPOL, 0: Vsync active level.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1: clock.
- RESET, in, 1: reset, asynchronous, active-high.
- PIX_EN, in, 1: pixel-advance strobe.
- RESTART, in, 1: synchronous timing restart.
- Hsync, out, 1: horizontal sync.
- Vsync, out, 1: vertical sync.
- DE, out, 1: active-video enable.
- hpos, out, 11: horizontal count.
- vpos, out, 10: vertical count.
- line_start, out, 1: one-CLK pulse at the start of a line.
- frame_start, out, 1: one-CLK pulse at the start of a frame.
- frame_cnt, out, 16: frame counter.

REQ-003 HTOTAL SHALL equal HSIZE+HFP+HSW+HBP (800 with defaults), and VTOTAL SHALL equal VSIZE+VFP+VSW+VBP (525 with defaults).
REQ-004 The parameters SHALL satisfy HTOTAL<=2048 and VTOTAL<=1024; out-of-range values are unsupported.

Function
REQ-005 All outputs SHALL be registered on posedge CLK, with no combinational path from any input to any output.
REQ-006 On a CLK edge with PIX_EN=1 and RESTART=0, hpos SHALL advance by 1, and SHALL wrap from HTOTAL-1 to 0.
REQ-007 When hpos wraps, vpos SHALL advance by 1, and SHALL wrap from VTOTAL-1 to 0; otherwise vpos SHALL hold.
REQ-008 On a CLK edge with PIX_EN=0 and RESTART=0, hpos, vpos, Hsync, Vsync, DE and frame_cnt SHALL hold, and line_start and frame_start SHALL be 0.
REQ-009 Hsync, Vsync and DE SHALL always be the decode of the hpos/vpos values presented in the same cycle (zero skew between them); the next-state position SHALL be decoded ahead of the register.
REQ-010 DE SHALL be 1 exactly when hpos<HSIZE and vpos<VSIZE.
REQ-011 Hsync SHALL equal HPOL exactly when HSIZE+HFP <= hpos < HSIZE+HFP+HSW (656..751 with defaults), and ~HPOL otherwise.
REQ-012 Vsync SHALL equal VPOL exactly when VSIZE+VFP <= vpos < VSIZE+VFP+VSW (490..491 with defaults), and ~VPOL otherwise; Vsync SHALL be line-aligned and change only when hpos becomes 0.
REQ-013 line_start SHALL be 1 for exactly the CLK cycle in which hpos has just become 0 through an advance.
REQ-014 frame_start SHALL be 1 for exactly the CLK cycle in which (hpos,vpos) has just become (0,0) through an advance; line_start SHALL also be 1 in that cycle.
REQ-015 frame_cnt SHALL increment by 1 in the same edge that raises frame_start, and SHALL wrap from 0xFFFF to 0x0000.
REQ-016 RESTART=1 on a CLK edge SHALL set hpos=HTOTAL-1 and vpos=VTOTAL-1, with Hsync, Vsync and DE decoded for that position.
REQ-017 During RESTART, line_start and frame_start SHALL be 0 and frame_cnt SHALL hold.
REQ-018 RESTART SHALL take priority over PIX_EN.
REQ-019 After RESTART, the first PIX_EN=1 edge with RESTART=0 SHALL produce (0,0) with frame_start=1.
REQ-020 A DE=1 run SHALL last exactly HSIZE PIX_EN advances per active line, and each frame SHALL contain exactly VSIZE such runs.

Reset
REQ-021 While RESET=1, the block SHALL immediately (asynchronously) force:
- hpos=HTOTAL-1, vpos=VTOTAL-1;
- DE=0, Hsync=~HPOL, Vsync=~VPOL;
- line_start=0, frame_start=0, frame_cnt=0.
REQ-022 The first PIX_EN=1 edge after RESET deasserts SHALL produce hpos=0, vpos=0, DE=1, line_start=1, frame_start=1 and frame_cnt=1.
REQ-023 RESET asserted mid-frame SHALL abandon the frame with no further pulses until the REQ-022 restart.

Verification
REQ-024 Reset release followed by PIX_EN held at 1 -> first cycle shows (0,0) with DE=1, frame_start=1 and frame_cnt=1; hpos=639 is the last DE=1 cycle and hpos=640 shows DE=0.
REQ-025 A full default frame run -> Hsync=0 for exactly hpos 656..751; Vsync=0 for exactly vpos 490..491; 525 line_start pulses between consecutive frame_start pulses, 420000 cycles apart.
REQ-026 PIX_EN=1 for 1 cycle in every 4 -> outputs hold between strobes; pulses last 1 CLK; the frame period is 1680000 CLK.
REQ-027 RESTART pulsed at (hpos,vpos)=(300,200) -> next cycle shows (799,524) with DE=0 and no pulse; the next advance gives (0,0) with frame_start=1 and frame_cnt incremented by 1.
REQ-028 RESET asserted asynchronously mid-line -> outputs reach reset values before the next CLK edge.
REQ-029 frame_cnt preloaded to 0xFFFF by running 65535 frames (or forced) -> the next frame_start gives frame_cnt=0x0000.
REQ-030 HPOL=1, VPOL=1 build -> sync levels are inverted and DE timing is unchanged.
